// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with carry, signed-overflow
// and zero flags under a start/busy/done handshake.
module addsub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_diff,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("addsub_serial: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   cin_msb;
  logic                   last;

  always_comb begin
    dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    res_cat = {dsum[DIGIT-1:0], res_q};
    // Carry into the top bit of this digit; on the last digit that is the carry into the MSB.
    cin_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    last    = (cnt_q == CntW'(N - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = minuend;
          b_d     = mode ? ~subtrahend : subtrahend;
          carry_d = mode;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum[DIGIT];
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          // Committed outputs change only here, so sum_diff never shows a partial result.
          sum_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
          cout_d  = dsum[DIGIT];
          ovf_d   = cin_msb ^ dsum[DIGIT];
          zero_d  = ~|res_cat[WIDTH+DIGIT-1:DIGIT];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign sum_diff  = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: three instances (8/1, 8/4, 16/2) sharing clock and reset.
module tb_addsub_serial;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v, done_v, c_v, v_v, z_v;
  logic [7:0]  sum0, sum1;
  logic [15:0] sum2;

  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clock(clk), .reset(reset), .start(start_v[0]), .mode(mode),
    .minuend(a16[7:0]), .subtrahend(b16[7:0]), .busy(busy_v[0]), .done(done_v[0]),
    .sum_diff(sum0), .carry_out(c_v[0]), .overflow(v_v[0]), .zero(z_v[0])
  );

  addsub_serial #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clock(clk), .reset(reset), .start(start_v[1]), .mode(mode),
    .minuend(a16[7:0]), .subtrahend(b16[7:0]), .busy(busy_v[1]), .done(done_v[1]),
    .sum_diff(sum1), .carry_out(c_v[1]), .overflow(v_v[1]), .zero(z_v[1])
  );

  addsub_serial #(.WIDTH(16), .DIGIT(2)) u_w16d2 (
    .clock(clk), .reset(reset), .start(start_v[2]), .mode(mode),
    .minuend(a16), .subtrahend(b16), .busy(busy_v[2]), .done(done_v[2]),
    .sum_diff(sum2), .carry_out(c_v[2]), .overflow(v_v[2]), .zero(z_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int inst);
    return (inst == 2) ? 16 : 8;
  endfunction

  function automatic int cycles_of(input int inst);
    return (inst == 1) ? 2 : 8;
  endfunction

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic m);
    exp_t        e;
    logic [16:0] mask, bb, full;
    logic        sa, sb, sr;
    mask  = (17'd1 << w) - 17'd1;
    bb    = m ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    full  = ({1'b0, a} & mask) + bb + {16'd0, m};
    e.sum = full[15:0] & mask[15:0];
    e.c   = full[w];
    sa    = a[w-1];
    sb    = b[w-1];
    sr    = e.sum[w-1];
    e.v   = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    e.z   = (e.sum == 16'd0);
    return e;
  endfunction

  task automatic check_out(input int inst, input logic [15:0] got);
    exp_t e;
    bit   have = 1'b0;
    case (inst)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk($sformatf("i%0d_done_without_op", inst), {31'd0, done_v[inst]}, 32'd0);
    end else begin
      chk($sformatf("i%0d_sum", inst), {16'd0, got}, {16'd0, e.sum});
      chk($sformatf("i%0d_carry", inst), {31'd0, c_v[inst]}, {31'd0, e.c});
      chk($sformatf("i%0d_ovf", inst), {31'd0, v_v[inst]}, {31'd0, e.v});
      chk($sformatf("i%0d_zero", inst), {31'd0, z_v[inst]}, {31'd0, e.z});
    end
  endtask

  // Output monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done_v[0]) check_out(0, {8'd0, sum0});
    if (done_v[1]) check_out(1, {8'd0, sum1});
    if (done_v[2]) check_out(2, sum2);
  end

  task automatic start_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input bit push);
    a16 = a;
    b16 = b;
    mode = m;
    start_v[inst] = 1'b1;
    if (push) begin
      case (inst)
        0: q0.push_back(model(width_of(inst), a, b, m));
        1: q1.push_back(model(width_of(inst), a, b, m));
        default: q2.push_back(model(width_of(inst), a, b, m));
      endcase
    end
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    chk($sformatf("i%0d_busy_after_start", inst), {31'd0, busy_v[inst]}, 32'd1);
  endtask

  // Leaves the caller 1 time unit after the edge that raised done (i.e. in the done cycle).
  task automatic wait_done(input int inst, input int n, input string tag);
    int cyc = 0;
    bit found = 1'b0;
    while (cyc < n + 4 && !found) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_v[inst]) found = 1'b1;
    end
    chk({tag, "_latency"}, cyc, n);
    chk({tag, "_busy_low_at_done"}, {31'd0, busy_v[inst]}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input int inst, input logic [15:0] a, input logic [15:0] b,
                    input logic m, input string tag);
    start_op(inst, a, b, m, 1'b1);
    wait_done(inst, cycles_of(inst), tag);
    idle(1);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("rst_done%0d", i), {31'd0, done_v[i]}, 32'd0);
      chk($sformatf("rst_flags%0d", i), {29'd0, c_v[i], v_v[i], z_v[i]}, 32'd0);
    end
    chk("rst_sum0", {24'd0, sum0}, 32'd0);
    chk("rst_sum2", {16'd0, sum2}, 32'd0);

    op(0, 16'd3, 16'd4, 1'b0, "add_3_4");
    op(0, 16'd5, 16'd2, 1'b1, "sub_5_2");
    op(0, 16'd7, 16'd7, 1'b1, "sub_7_7");
    op(0, 16'd8, 16'd9, 1'b1, "sub_8_9");
    op(0, 16'd127, 16'd1, 1'b0, "add_127_1");
    op(0, 16'd255, 16'd1, 1'b0, "add_255_1");
    op(0, 16'h80, 16'd1, 1'b1, "sub_80_1");

    // Start during run is ignored
    start_op(0, 16'd6, 16'd5, 1'b0, 1'b1);
    idle(2);
    a16 = 16'd15;
    b16 = 16'd12;
    mode = 1'b1;
    start_v[0] = 1'b1;
    idle(1);
    start_v[0] = 1'b0;
    wait_done(0, 5, "ignored_start");

    // Back-to-back start in the done cycle
    start_op(0, 16'd7, 16'd7, 1'b0, 1'b1);
    chk("b2b_done_drops", {31'd0, done_v[0]}, 32'd0);
    wait_done(0, 8, "b2b_7_7");
    idle(1);

    // Reset mid-operation: no done, committed result cleared
    start_op(0, 16'd9, 16'd9, 1'b0, 1'b0);
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("midrst_sum", {24'd0, sum0}, 32'd0);
    chk("midrst_flags", {29'd0, c_v[0], v_v[0], z_v[0]}, 32'd0);
    idle(12);
    op(0, 16'd1, 16'd1, 1'b0, "add_1_1");

    op(1, 16'd15, 16'd12, 1'b1, "d4_sub_15_12");
    op(1, 16'd100, 16'd60, 1'b0, "d4_add_100_60");
    op(2, 16'hFFFF, 16'h0001, 1'b0, "d2_add_ffff_1");
    op(2, 16'h8000, 16'h0001, 1'b1, "d2_sub_8000_1");

    for (int i = 0; i < 6; i++) begin
      op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
         "rand_w8");
      op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rand_w16");
    end

    idle(3);
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
Parametrised, multi-cycle, digit-serial adder/subtractor. It is the sequential successor to the 4-bit combinational adder/subtractor. Operands are latched on a Start pulse. The block processes DIGIT bits per clock, LSB first, and returns the result with carry, signed-overflow and zero flags under a Start/Busy/Done handshake. It lets wide add/subtract share a narrow DIGIT-bit adder slice in area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
DIGIT, 1, bits processed per clock; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Start  in  1  request; sampled only when Busy=0
Mode  in  1  0 = add (Minuend+Subtrahend), 1 = subtract (Minuend-Subtrahend)
Minuend  in  WIDTH  operand A
Subtrahend  in  WIDTH  operand B
Busy  out  1  operation in progress
Done  out  1  one-cycle pulse, result valid
SumDiff  out  WIDTH  result
CarryOut  out  1  carry out of MSB (subtract: 1 = no borrow)
Overflow  out  1  two's-complement signed overflow
Zero  out  1  SumDiff == 0

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Reset=1 at an edge forces IDLE. Busy, Done, SumDiff, CarryOut, Overflow and Zero all go to 0, and internal shift registers and carry are cleared. Reset mid-operation aborts it: no Done, previous result is discarded and reads 0.
- N = WIDTH/DIGIT cycles per operation.
- FSM has two states, IDLE and RUN.
- IDLE, Start=1 at edge E0:
  - Latch A=Minuend.
  - Latch B=Subtrahend, or ~Subtrahend when Mode=1.
  - Carry register = Mode.
  - Clear result shift register and go to RUN. Busy=1 from E0.
- RUN:
  - At edges E1..EN, add the low DIGIT bits of A and B plus the carry.
  - Shift the DIGIT-bit sum into the result register from the MSB side.
  - Shift A and B right by DIGIT and update the carry.
  - Keep the carry into bit WIDTH-1 for the overflow flag.
- At EN:
  - Commit SumDiff, CarryOut = final carry, Overflow = carry-into-MSB XOR carry-out, Zero = (result == 0).
  - Done=1 for exactly the cycle after EN. Busy=0 from EN. Return to IDLE.
- Latency: Start sampled at E0, result and Done visible after EN (N cycles).
- Outputs hold their last committed values until the next EN or Reset. SumDiff is never partially updated while Busy.
- Start while Busy=1 is ignored; operand, Mode and Start changes during RUN have no effect.
- Back-to-back: Start=1 in the Done cycle is accepted (Busy=0 there). The new operation begins at that edge and Done drops.
- Reset and Start both high at the same edge: Reset wins.
- Arithmetic is modulo 2^WIDTH. CarryOut is the unsigned carry/no-borrow; Overflow is signed.
  - Add: Overflow when the operands have the same sign and the result sign differs.
  - Subtract: Overflow when the operands have different signs and the result sign differs from the Minuend's.

Test Plan:
1. WIDTH=8, DIGIT=1:
   - Reset 2 cycles -> all outputs 0.
   - Start with 3+4, Mode=0 -> Busy for 8 cycles, Done pulse after E8, SumDiff=7, CarryOut=0, Overflow=0, Zero=0.
2. Subtract, WIDTH=8, DIGIT=1:
   - 5-2 -> SumDiff=3, CarryOut=1.
   - 7-7 -> SumDiff=0, Zero=1, CarryOut=1.
   - 8-9 -> SumDiff=0xFF, CarryOut=0, Overflow=0.
3. Boundaries, WIDTH=8, DIGIT=1:
   - 127+1 -> 0x80, Overflow=1, CarryOut=0.
   - 255+1 -> 0x00, CarryOut=1, Zero=1, Overflow=0.
   - 0x80-1 -> 0x7F, Overflow=1, CarryOut=1.
4. Handshake:
   - Start 6+5, then at E3 pulse Start with 15-12 and Mode=1 -> ignored; result 11 after E8.
   - Start asserted in the Done cycle with 7+7 -> accepted; second Done 8 cycles later, SumDiff=14.
5. Reset mid-operation: Start 9+9, Reset at E4 -> Busy=0 and outputs 0 after E4, no Done ever. Next Start 1+1 -> 2 normally.
6. WIDTH=8, DIGIT=4 instance: 15-12 -> Done after E2, SumDiff=3, CarryOut=1. WIDTH=16, DIGIT=2: 0xFFFF+0x0001 -> 0x0000, CarryOut=1, Done after E8.
